// File: rtl/quant_block_pipe.sv
// rtl/quant_block_pipe.sv - handshaked lane-parallel 4x4 block quantizer with zigzag output
//
// Accepts a 4x4 coefficient block plus its quant tables, quantizes LANES
// coefficients per cycle through a two-stage pipeline, and holds the
// zigzag-ordered levels, raster dequantized values, nz flag and end-of-block
// index until the consumer takes them.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   block handshake; in_ready only high in IDLE
//   in                    16 signed IW-bit coefficients, raster order
//   q, iq, sharpen        16-bit unsigned per-coefficient tables
//   bias, zthresh         32-bit unsigned per-coefficient tables
//   sharpen_en            when low, sharpen is treated as zero
//   out_valid / out_ready result handshake
//   out                   16 signed 16-bit levels, zigzag order
//   rout                  16 signed 16-bit dequantized values, raster order
//   nz                    any level nonzero
//   eob                   last nonzero zigzag position + 1, 0 if none
module quant_block_pipe #(
  parameter int IW        = 16,
  parameter int LANES     = 4,
  parameter int QFIX      = 17,
  parameter int MAX_LEVEL = 2047
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [16*IW-1:0] in,
  input  logic [255:0]     q,
  input  logic [255:0]     iq,
  input  logic [255:0]     sharpen,
  input  logic [511:0]     bias,
  input  logic [511:0]     zthresh,
  input  logic             sharpen_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [255:0]     out,
  output logic [255:0]     rout,
  output logic             nz,
  output logic [4:0]       eob
);

  localparam int NBLK = 16 / LANES;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t     state;
  logic [4:0] cnt;

  // Captured block and tables; sharpen is folded to zero at capture when
  // disabled so the datapath never has to look at sharpen_en again.
  logic [IW-1:0] c_in   [16];
  logic [15:0]   c_q    [16];
  logic [15:0]   c_iq   [16];
  logic [15:0]   c_sh   [16];
  logic [31:0]   c_bias [16];
  logic [31:0]   c_zt   [16];

  // Issue (stage 1 input) combinational values, one per lane
  logic [3:0]  iss_idx   [LANES];
  logic        iss_sign  [LANES];
  logic [31:0] iss_sx    [LANES];
  logic [31:0] iss_mag   [LANES];
  logic [31:0] iss_coeff [LANES];
  logic [31:0] iss_level [LANES];
  logic        iss_pass  [LANES];

  // Stage 1 registers
  logic [3:0]  s1_idx   [LANES];
  logic [31:0] s1_level [LANES];
  logic        s1_pass  [LANES];
  logic        s1_sign  [LANES];
  logic        s1_vld;
  logic        s1_last;
  logic        s2_last;

  // Stage 2 combinational values
  logic [15:0] s2_lv   [LANES];
  logic [15:0] s2_out  [LANES];
  logic [15:0] s2_rout [LANES];

  // Working arrays filled by stage 2, raster order
  logic [15:0] out_r  [16];
  logic [15:0] rout_r [16];

  // Result values assembled from the completed working arrays
  logic [255:0] res_out;
  logic [255:0] res_rout;
  logic [4:0]   res_eob;

  function automatic logic [3:0] zz(input int k);
    case (k)
      0:       zz = 4'd0;
      1:       zz = 4'd1;
      2:       zz = 4'd4;
      3:       zz = 4'd8;
      4:       zz = 4'd5;
      5:       zz = 4'd2;
      6:       zz = 4'd3;
      7:       zz = 4'd6;
      8:       zz = 4'd9;
      9:       zz = 4'd12;
      10:      zz = 4'd13;
      11:      zz = 4'd10;
      12:      zz = 4'd7;
      13:      zz = 4'd11;
      14:      zz = 4'd14;
      default: zz = 4'd15;
    endcase
  endfunction

  // Stage 1 arithmetic. All products and sums are 32-bit and wrap; the
  // magnitude of the most negative input (2^(IW-1)) still fits.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      iss_idx[l]   = 4'(int'(cnt) * LANES + l);
      iss_sign[l]  = c_in[iss_idx[l]][IW-1];
      iss_sx[l]    = {{(32-IW){iss_sign[l]}}, c_in[iss_idx[l]]};
      iss_mag[l]   = iss_sign[l] ? (32'd0 - iss_sx[l]) : iss_sx[l];
      iss_coeff[l] = iss_mag[l] + {16'd0, c_sh[iss_idx[l]]};
      iss_level[l] = (iss_coeff[l] * {16'd0, c_iq[iss_idx[l]]} + c_bias[iss_idx[l]]) >> QFIX;
      iss_pass[l]  = iss_coeff[l] > c_zt[iss_idx[l]];
    end
  end

  // Stage 2: clamp, re-sign, dequantize. Only the low 16 bits of the
  // dequant product are kept, which are identical for signed and unsigned.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      s2_lv[l]   = (s1_level[l] > 32'(MAX_LEVEL)) ? 16'(MAX_LEVEL) : s1_level[l][15:0];
      s2_out[l]  = !s1_pass[l] ? 16'd0 : (s1_sign[l] ? (16'd0 - s2_lv[l]) : s2_lv[l]);
      s2_rout[l] = s2_out[l] * c_q[s1_idx[l]];
    end
  end

  // Zigzag reorder and end-of-block scan over the completed block
  always_comb begin
    res_out  = '0;
    res_rout = '0;
    res_eob  = '0;
    for (int k = 0; k < 16; k++) begin
      res_out[16*k +: 16]  = out_r[zz(k)];
      res_rout[16*k +: 16] = rout_r[k];
      if (out_r[zz(k)] != 16'd0) res_eob = 5'(k + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      rout      <= '0;
      nz        <= 1'b0;
      eob       <= '0;
      s1_vld    <= 1'b0;
      s1_last   <= 1'b0;
      s2_last   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        c_in[i]   <= '0;
        c_q[i]    <= '0;
        c_iq[i]   <= '0;
        c_sh[i]   <= '0;
        c_bias[i] <= '0;
        c_zt[i]   <= '0;
        out_r[i]  <= '0;
        rout_r[i] <= '0;
      end
      for (int l = 0; l < LANES; l++) begin
        s1_idx[l]   <= '0;
        s1_level[l] <= '0;
        s1_pass[l]  <= 1'b0;
        s1_sign[l]  <= 1'b0;
      end
    end else begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s2_last <= s1_last;

      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_ready && in_valid) begin
            for (int i = 0; i < 16; i++) begin
              c_in[i]   <= in[IW*i +: IW];
              c_q[i]    <= q[16*i +: 16];
              c_iq[i]   <= iq[16*i +: 16];
              c_sh[i]   <= sharpen_en ? sharpen[16*i +: 16] : 16'd0;
              c_bias[i] <= bias[32*i +: 32];
              c_zt[i]   <= zthresh[32*i +: 32];
            end
            in_ready <= 1'b0;
            cnt      <= '0;
            state    <= RUN;
          end
        end

        RUN: begin
          if (cnt < 5'(NBLK)) begin
            for (int l = 0; l < LANES; l++) begin
              s1_idx[l]   <= iss_idx[l];
              s1_level[l] <= iss_level[l];
              s1_pass[l]  <= iss_pass[l];
              s1_sign[l]  <= iss_sign[l];
            end
            s1_vld  <= 1'b1;
            s1_last <= (cnt == 5'(NBLK - 1));
            cnt     <= cnt + 5'd1;
          end
          // s2_last means the final stage-2 write landed on the previous edge
          if (s2_last) begin
            out       <= res_out;
            rout      <= res_rout;
            eob       <= res_eob;
            nz        <= (res_eob != 5'd0);
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      if (s1_vld) begin
        for (int l = 0; l < LANES; l++) begin
          out_r[s1_idx[l]]  <= s2_out[l];
          rout_r[s1_idx[l]] <= s2_rout[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_quant_block_pipe.sv
// tb/tb_quant_block_pipe.sv - directed bench for quant_block_pipe at LANES 1, 2, 4, 16
module tb_quant_block_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, sharpen_en, out_ready;
  logic [255:0] in_v, q, iq, sharpen;
  logic [511:0] bias, zthresh;

  logic         ir   [4];
  logic         ov   [4];
  logic         nzv  [4];
  logic [255:0] o    [4];
  logic [255:0] r    [4];
  logic [4:0]   eobv [4];

  quant_block_pipe #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in(in_v),
    .q(q), .iq(iq), .sharpen(sharpen), .bias(bias), .zthresh(zthresh),
    .sharpen_en(sharpen_en), .out_valid(ov[0]), .out_ready(out_ready),
    .out(o[0]), .rout(r[0]), .nz(nzv[0]), .eob(eobv[0]));

  quant_block_pipe #(.LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in(in_v),
    .q(q), .iq(iq), .sharpen(sharpen), .bias(bias), .zthresh(zthresh),
    .sharpen_en(sharpen_en), .out_valid(ov[1]), .out_ready(out_ready),
    .out(o[1]), .rout(r[1]), .nz(nzv[1]), .eob(eobv[1]));

  quant_block_pipe #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in(in_v),
    .q(q), .iq(iq), .sharpen(sharpen), .bias(bias), .zthresh(zthresh),
    .sharpen_en(sharpen_en), .out_valid(ov[2]), .out_ready(out_ready),
    .out(o[2]), .rout(r[2]), .nz(nzv[2]), .eob(eobv[2]));

  quant_block_pipe #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .in(in_v),
    .q(q), .iq(iq), .sharpen(sharpen), .bias(bias), .zthresh(zthresh),
    .sharpen_en(sharpen_en), .out_valid(ov[3]), .out_ready(out_ready),
    .out(o[3]), .rout(r[3]), .nz(nzv[3]), .eob(eobv[3]));

  int n_cmp  = 0;
  int n_fail = 0;
  int lat [4];
  int exp_lat [4] = '{18, 10, 6, 3};

  logic [255:0] exp_o, exp_r;
  logic         exp_nz;
  logic [4:0]   exp_eob;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_defaults();
    in_v       = '0;
    sharpen    = '0;
    bias       = '0;
    zthresh    = '0;
    sharpen_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      q[16*i +: 16]  = 16'd16;
      iq[16*i +: 16] = 16'd8192;
    end
    exp_o   = '0;
    exp_r   = '0;
    exp_nz  = 1'b0;
    exp_eob = '0;
  endtask

  // Accept a block on all four instances and record the out_valid latency
  // of each, counted in edges after the accepting edge. out_ready is pulsed
  // during RUN, where it must be ignored.
  task automatic run_block(input string tag);
    chk({tag, "_in_ready"}, ir[2], 1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int d = 0; d < 4; d++) lat[d] = -1;
    out_ready = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      out_ready = 1'b0;
      for (int d = 0; d < 4; d++) if (ov[d] && lat[d] < 0) lat[d] = n;
      if (lat[0] > 0) break;
    end
    for (int d = 0; d < 4; d++)
      chk($sformatf("%s_lat%0d", tag, d), 256'(lat[d]), 256'(exp_lat[d]));
  endtask

  task automatic check_results(input string tag);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_out%0d", tag, d), o[d], exp_o);
      chk($sformatf("%s_rout%0d", tag, d), r[d], exp_r);
      chk($sformatf("%s_nz%0d", tag, d), nzv[d], exp_nz);
      chk($sformatf("%s_eob%0d", tag, d), eobv[d], exp_eob);
    end
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_take_ov%0d", tag, d), ov[d], 0);
      chk($sformatf("%s_take_ir%0d", tag, d), ir[d], 1);
    end
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_defaults();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_ir%0d", d), ir[d], 0);
      chk($sformatf("rst_ov%0d", d), ov[d], 0);
    end
    check_results("rst");
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) chk($sformatf("rel_ir%0d", d), ir[d], 1);

    // Single positive coefficient: 100*8192>>17 = 6, 6*16 = 96
    set_defaults();
    in_v[15:0]    = 16'd100;
    exp_o[15:0]   = 16'd6;
    exp_r[15:0]   = 16'd96;
    exp_nz        = 1'b1;
    exp_eob       = 5'd1;
    run_block("single");
    check_results("single");
    take("single");
    chk("keep_idle_out", o[2], exp_o);

    // Negative coefficient at raster 5 -> zigzag position 4
    set_defaults();
    in_v[16*5 +: 16]  = 16'hFF9C;
    exp_o[16*4 +: 16] = 16'hFFFA;
    exp_r[16*5 +: 16] = 16'hFFA0;
    exp_nz            = 1'b1;
    exp_eob           = 5'd5;
    run_block("neg");
    check_results("neg");
    take("neg");

    // Clamp: 32767*65535>>17 = 16383 -> 2047, 2047*16 = 32752
    set_defaults();
    for (int i = 0; i < 16; i++) iq[16*i +: 16] = 16'hFFFF;
    in_v[15:0]  = 16'h7FFF;
    exp_o[15:0] = 16'h07FF;
    exp_r[15:0] = 16'h7FF0;
    exp_nz      = 1'b1;
    exp_eob     = 5'd1;
    run_block("clamp");
    check_results("clamp");
    take("clamp");

    // Threshold not passed: coeff 100 is not > 100
    set_defaults();
    for (int i = 0; i < 16; i++) zthresh[32*i +: 32] = 32'd100;
    in_v[15:0] = 16'd100;
    run_block("thresh");
    check_results("thresh");
    take("thresh");

    // Sharpen lifts coeff to 101: 101*8192>>17 = 6
    for (int i = 0; i < 16; i++) sharpen[16*i +: 16] = 16'd1;
    sharpen_en  = 1'b1;
    exp_o[15:0] = 16'd6;
    exp_r[15:0] = 16'd96;
    exp_nz      = 1'b1;
    exp_eob     = 5'd1;
    run_block("sharpen");
    check_results("sharpen");
    take("sharpen");

    // Only raster 2 nonzero -> zigzag position 5, eob 6
    set_defaults();
    in_v[16*2 +: 16]  = 16'd100;
    exp_o[16*5 +: 16] = 16'd6;
    exp_r[16*2 +: 16] = 16'd96;
    exp_nz            = 1'b1;
    exp_eob           = 5'd6;
    run_block("eob6");
    check_results("eob6");
    take("eob6");

    // Only raster 15 nonzero -> eob 16, then hold under backpressure
    set_defaults();
    in_v[16*15 +: 16]  = 16'd100;
    exp_o[16*15 +: 16] = 16'd6;
    exp_r[16*15 +: 16] = 16'd96;
    exp_nz             = 1'b1;
    exp_eob            = 5'd16;
    run_block("eob16");
    check_results("eob16");
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk($sformatf("bp_ov_%0d", n), ov[2], 1);
      chk($sformatf("bp_ir_%0d", n), ir[2], 0);
      chk($sformatf("bp_out_%0d", n), o[2], exp_o);
      chk($sformatf("bp_rout_%0d", n), r[2], exp_r);
    end
    take("eob16");

    // Reset pulse mid-RUN discards the block
    set_defaults();
    in_v[15:0] = 16'd100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_results("midrst");
    for (int d = 0; d < 4; d++) chk($sformatf("midrst_ov%0d", d), ov[d], 0);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) if (ov[d]) seen = 1;
    end
    chk("midrst_no_valid", 256'(seen), 0);

    // Next block after reset: 200*8192>>17 = 12, 12*16 = 192
    in_v[15:0]  = 16'd200;
    exp_o[15:0] = 16'd12;
    exp_r[15:0] = 16'd192;
    exp_nz      = 1'b1;
    exp_eob     = 5'd1;
    run_block("after");
    check_results("after");
    take("after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/quant_block_pipe.md
# quant_block_pipe

Handshaked, lane-parallel successor to the single-shot 4x4 quantizer in the encoder's transform/quant path. Accepts one 4x4 coefficient block plus its quant matrix on a valid/ready handshake. Quantizes LANES coefficients per cycle through a 2-stage pipeline and holds the zigzag-ordered levels, raster dequantized values, nz flag and end-of-block index until the consumer takes them. It sits between the forward transform and the token/reconstruction stages.

## Interface
- IW, 16: input coefficient width, two's complement.
- LANES, 4: coefficients processed per cycle; legal values 1, 2, 4, 8, 16.
- QFIX, 17: right-shift applied after multiply-add.
- MAX_LEVEL, 2047: clamp for the quantized magnitude.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  block and tables present
- in_ready  out  1  block accepted when in_valid & in_ready
- in  in  16*IW  coefficients, raster order, index i at [IW*i +: IW]
- q, iq, sharpen  in  256 each  16-bit unsigned per coefficient
- bias, zthresh  in  512 each  32-bit unsigned per coefficient
- sharpen_en  in  1  when 0, sharpen is treated as 0
- out_valid  out  1  results valid
- out_ready  in  1  consumer takes results
- out  out  256  signed 16-bit levels, zigzag order
- rout  out  256  signed 16-bit dequantized values, raster order
- nz  out  1  any level nonzero
- eob  out  5  last nonzero zigzag position + 1, or 0 if none

## Operation
- FSM has three states: IDLE, RUN, HOLD.
  - IDLE: in_ready=1. On handshake, capture in, q, iq, bias, zthresh, sharpen and sharpen_en into registers. Clear cnt, then go to RUN.
  - RUN: in_ready=0. Issue coefficients cnt*LANES .. cnt*LANES+LANES-1 to stage 1 and increment cnt.
  - After the last issue, wait for the pipeline to drain, then go to HOLD.
  - HOLD: out_valid=1. On out_ready, go to IDLE.
  - in_valid is ignored outside IDLE.
- Per-coefficient arithmetic:
  - sign is the MSB of in[i].
  - coeff is 32-bit unsigned: |in[i]| + (sharpen_en ? sharpen[i] : 0).
  - Stage 1 registers level = (coeff*iq[i] + bias[i]) >> QFIX, using a 32-bit product and sum with wrap on overflow. It also registers coeff > zthresh[i] and sign.
  - Stage 2 computes lv = min(level, MAX_LEVEL).
    - If the threshold passed: out_r[i] = sign ? -lv : lv, and rout[i] = low 16 bits of out_r[i]*q[i] (signed).
    - Otherwise: out_r[i] = 0 and rout[i] = 0.
- Zigzag mapping, out position k takes raster index: 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
- nz and eob are computed from the completed out_r array. They are registered together with out_valid.
- Result registers keep their value from the last block through IDLE and RUN. They are overwritten only by a new block.

## Timing
- Reset values:
  - in_ready=0 during reset and 1 from the first clock edge after release.
  - out_valid=0, out=0, rout=0, nz=0, eob=0, state=IDLE, cnt=0.
- Latency: if the accepting edge is E0, out_valid rises at edge E0 + 16/LANES + 2. LANES=4 gives 6 cycles; LANES=16 gives 3.
- out_valid stays high with stable data until the out_ready edge, and falls on that same edge.
- A new block is accepted no earlier than the edge after the output handshake, giving a minimum block period of 16/LANES + 4 cycles.
- out_ready asserted before out_valid has no effect.
- If reset asserts mid-RUN or mid-HOLD, everything clears immediately, the partial block is discarded and no out_valid occurs.

## Test plan
- Single coefficient, LANES=4: in[0]=100, q=16, iq=8192, bias=0, zthresh=0, sharpen_en=0 -> out[0]=6, rout[0]=96, nz=1, eob=1, out_valid at E0+6.
- Negative and sign path: in[5]=-100, other values as above -> out[4]=-6 (zigzag position of raster 5), rout[5]=-96, eob=5.
- Clamp: in[0]=32767, iq=65535, bias=0 -> level 16383 clamped, out[0]=2047, rout[0]=32752.
- Threshold and sharpen:
  - coeff 100 with zthresh=100 -> out=0, nz=0, eob=0.
  - Same block with sharpen=1, sharpen_en=1 -> out[0]=6, nz=1.
- eob ordering: only raster 2 nonzero -> eob=6; only raster 15 nonzero -> eob=16.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout.
  - Pulse rst_n low mid-RUN -> out_valid never rises and the next block's results are correct.
  - Repeat for LANES = 1, 2 and 16 with the latencies checked.
